// File: rtl/taillight_seq_pkg.sv
// Shared state codes, lamp width and the sweep pattern for the taillight controller.
package taillight_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SIG_L     = 3'd1,
        ST_SIG_R     = 3'd2,
        ST_BRK       = 3'd3,
        ST_BRK_SIG_L = 3'd4,
        ST_BRK_SIG_R = 3'd5,
        ST_HZRD      = 3'd6,
        ST_UNUSED    = 3'd7
    } state_t;

    localparam int LED_W = 3;

    localparam logic [LED_W-1:0] LED_OFF = 3'b000;
    localparam logic [LED_W-1:0] LED_ALL = 3'b111;

    // Thunderbird sweep: lamps light from the inside out, one per phase.
    function automatic logic [LED_W-1:0] sweep(input logic [1:0] phase);
        logic [LED_W-1:0] pat;
        case (phase)
            2'd0:    pat = 3'b000;
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            default: pat = 3'b111;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Animation-step prescaler: counts 0..TICK_DIV-1, flags the terminal count,
// and restarts from zero whenever the controller state changes.
module tick_gen #(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/taillight_seq.sv
// Output side of the sequential-taillight controller: registers the state word,
// steps the animation phase on each prescaler tick and decodes the lamp patterns.
module taillight_seq
    import taillight_seq_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       current_state,
    output logic [LED_W-1:0] led_l,
    output logic [LED_W-1:0] led_r,
    output logic             step_tick
);

    state_t     state_q;
    logic [1:0] phase;
    logic       change;
    logic       tick;

    assign change = (current_state != state_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (change),
        .tick (tick)
    );

    // Any state change restarts the animation, even when it lands on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase   <= 2'd0;
        end else if (change) begin
            state_q <= state_t'(current_state);
            phase   <= 2'd0;
        end else if (tick) begin
            phase   <= phase + 2'd1;
        end
    end

    assign step_tick = tick;

    always_comb begin
        led_l = LED_OFF;
        led_r = LED_OFF;
        case (state_q)
            ST_SIG_L:     led_l = sweep(phase);
            ST_SIG_R:     led_r = sweep(phase);
            ST_BRK: begin
                led_l = LED_ALL;
                led_r = LED_ALL;
            end
            ST_BRK_SIG_L: begin
                led_l = sweep(phase);
                led_r = LED_ALL;
            end
            ST_BRK_SIG_R: begin
                led_l = LED_ALL;
                led_r = sweep(phase);
            end
            ST_HZRD: begin
                led_l = phase[0] ? LED_OFF : LED_ALL;
                led_r = phase[0] ? LED_OFF : LED_ALL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_taillight_seq.sv
// Directed plus randomized check of taillight_seq against a clocks-since-change model.
module tb_taillight_seq;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] current_state = 3'd0;
    logic [2:0] led_l, led_r;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    // model: state seen by the lamps and clocks elapsed since it was adopted
    int m_state = 0;
    int m_k = 0;

    taillight_seq #(.TICK_DIV(TDIV), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .led_l         (led_l),
        .led_r         (led_r),
        .step_tick     (step_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pat_sweep(input int p);
        logic [3:0] v;
        v = (4'd1 << p) - 4'd1;
        return v[2:0];
    endfunction

    task automatic expected(output logic [2:0] el, output logic [2:0] er, output logic et);
        int p;
        p  = (m_k / TDIV) % 4;
        et = (rst == 1'b0) && ((m_k % TDIV) == TDIV - 1);
        el = 3'b000;
        er = 3'b000;
        if (!rst) begin
            case (m_state)
                1: el = pat_sweep(p);
                2: er = pat_sweep(p);
                3: begin el = 3'b111; er = 3'b111; end
                4: begin el = pat_sweep(p); er = 3'b111; end
                5: begin el = 3'b111; er = pat_sweep(p); end
                6: begin el = (p % 2 == 0) ? 3'b111 : 3'b000; er = el; end
                default: ;
            endcase
        end
    endtask

    task automatic check_out(input string tag);
        logic [2:0] el, er;
        logic       et;
        expected(el, er, et);
        checks++;
        assert (led_l === el) else begin
            errors++;
            $error("FAIL %s led_l: got %b expected %b (state %0d k %0d)", tag, led_l, el, m_state, m_k);
        end
        checks++;
        assert (led_r === er) else begin
            errors++;
            $error("FAIL %s led_r: got %b expected %b (state %0d k %0d)", tag, led_r, er, m_state, m_k);
        end
        checks++;
        assert (step_tick === et) else begin
            errors++;
            $error("FAIL %s step_tick: got %b expected %b (state %0d k %0d)", tag, step_tick, et, m_state, m_k);
        end
    endtask

    // Called at a negedge: present s, take one rising edge, check at the next negedge.
    task automatic step(input logic [2:0] s, input string tag);
        current_state = s;
        @(posedge clk);
        if (int'(s) != m_state) begin
            m_state = int'(s);
            m_k = 0;
        end else begin
            m_k++;
        end
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic hold(input logic [2:0] s, input int n, input string tag);
        for (int i = 0; i < n; i++) step(s, tag);
    endtask

    initial begin
        @(negedge clk);
        check_out("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_out("post_reset");

        // Async reset in the middle of hazard flashing
        hold(3'd6, 6, "hzrd_pre_rst");
        #2 rst = 1'b1;
        #1;
        m_state = 0;
        m_k = 0;
        check_out("async_rst");
        current_state = 3'd0;
        @(negedge clk);
        check_out("rst_held");
        rst = 1'b0;
        hold(3'd0, 8, "after_rst");

        hold(3'd1, 21, "sig_l");
        hold(3'd5, 17, "brk_sig_r");
        hold(3'd5, 2, "brk_sig_r");
        step(3'd3, "brk_mid_sweep");
        hold(3'd3, 3, "brk");
        hold(3'd6, 17, "hzrd");
        step(3'd0, "hzrd_to_idle");

        // SIG_L -> SIG_R exactly on the terminal-count edge
        hold(3'd1, 4, "sig_l_pre");
        while ((m_k % TDIV) != TDIV - 1) step(3'd1, "sig_l_align");
        hold(3'd2, 6, "change_on_tick");

        hold(3'd7, 6, "code7");
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 3'd1 : 3'd0, "toggle");
        hold(3'd4, 10, "brk_sig_l");

        for (int n = 0; n < 250; n++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            hold(s, int'($urandom_range(1, 14)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
